// File: rtl/upg_word_loader.sv
// upg_word_loader
//   UART-programmer initiator: receives a framed program image byte by byte,
//   packs each group of 4 bytes little-endian into a 32-bit word and writes it
//   to the data memory through the UPG write port. The frame is
//   count_lo, count_hi, 4*N data bytes, then one XOR checksum byte.
//   done is raised once the load ends (ok or failed) and hands the memory to the CPU.
// Ports
//   upg_clk_i   UPG clock
//   upg_rst_i   asynchronous active-high reset
//   rx_data_i   received byte, valid while rx_valid_i is high (one-cycle pulse)
//   upg_wen_o   one-cycle word write strobe
//   upg_adr_o   word address of the write (holds between strobes)
//   upg_dat_o   write data {b3,b2,b1,b0} (holds between strobes)
//   upg_done_o  load finished, sticky until reset
//   upg_err_o   load failed (bad count, checksum, timeout), sticky
//   busy_o      load in progress (HDR_HI, DATA or CSUM)
module upg_word_loader #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o,
  output logic              busy_o
);

  localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     MAX_WORDS = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, HDR_HI, DATA, CSUM, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        count_lo;
  logic [15:0]       last_idx;     // N-1, index of the final word
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       lane;         // bytes 0..2 of the word being assembled
  logic [7:0]        csum;
  logic [TW-1:0]     to_cnt;
  logic              err;
  logic              err_set;

  logic [15:0] hdr_n;
  logic        hdr_bad;
  logic        word_done;
  logic        last_word;
  logic        timeout;

  assign hdr_n     = {rx_data_i, count_lo};
  assign hdr_bad   = (hdr_n == 16'd0) || (32'(hdr_n) > MAX_WORDS);
  assign word_done = (state == DATA) && rx_valid_i && (byte_idx == 2'd3);
  assign last_word = (32'(word_idx) == 32'(last_idx));
  assign busy_o    = (state == HDR_HI) || (state == DATA) || (state == CSUM);
  // Counter saturates at TO_LAST; an idle cycle spent there ends the load.
  assign timeout   = busy_o && !rx_valid_i && (to_cnt == TO_LAST);

  assign upg_done_o = (state == DONE);
  assign upg_err_o  = err;

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE:   if (rx_valid_i) state_nxt = HDR_HI;
      HDR_HI: if (rx_valid_i) begin
                if (hdr_bad) begin
                  state_nxt = DONE;
                  err_set   = 1'b1;
                end else begin
                  state_nxt = DATA;
                end
              end
      // Leave on the last byte; its strobe fires in the first CSUM cycle.
      DATA:   if (word_done && last_word) state_nxt = CSUM;
      CSUM:   if (rx_valid_i) begin
                state_nxt = DONE;
                err_set   = (rx_data_i != csum);
              end
      DONE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt = DONE;
      err_set   = 1'b1;
    end
  end

  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      upg_wen_o <= 1'b0;
      upg_adr_o <= '0;
      upg_dat_o <= '0;
      count_lo  <= '0;
      last_idx  <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      lane      <= '0;
      csum      <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      upg_wen_o <= word_done;
      if (err_set) err <= 1'b1;

      if (rx_valid_i || !busy_o)  to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

      if (state == IDLE && rx_valid_i) count_lo <= rx_data_i;

      if (state == HDR_HI && rx_valid_i) begin
        last_idx <= hdr_n - 16'd1;
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end

      if (state == DATA && rx_valid_i) begin
        byte_idx <= byte_idx + 2'd1;
        csum     <= csum ^ rx_data_i;
        case (byte_idx)
          2'd0:    lane[7:0]   <= rx_data_i;
          2'd1:    lane[15:8]  <= rx_data_i;
          2'd2:    lane[23:16] <= rx_data_i;
          default: begin
            upg_adr_o <= word_idx;
            upg_dat_o <= {rx_data_i, lane};
            if (!last_word) word_idx <= word_idx + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_upg_word_loader.sv
// Bench for upg_word_loader: directed frames from the test plan plus random
// frames, each compared against a frame-level model of the expected writes,
// write timing and final done/err.
module tb_upg_word_loader;
  localparam int ADDR_W = 14;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              wen;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat;
  logic              done, err, busy;

  upg_word_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .upg_clk_i(clk), .upg_rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .upg_wen_o(wen), .upg_adr_o(adr), .upg_dat_o(dat),
    .upg_done_o(done), .upg_err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observed writes
  int          wr_adr[$];
  logic [31:0] wr_dat[$];
  int          wr_cyc[$];
  always @(negedge clk) if (wen === 1'b1) begin
    wr_adr.push_back(int'(adr));
    wr_dat.push_back(dat);
    wr_cyc.push_back(cyc);
  end

  logic [7:0] frame[$];
  int         tms[$];

  task automatic clear_obs();
    wr_adr.delete(); wr_dat.delete(); wr_cyc.delete(); tms.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // drive one byte after 'gap' idle cycles; returns the cycle it is presented in
  task automatic send(input logic [7:0] b, input int gap, output int t);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); rx_valid = 1'b0;
    end
    @(negedge clk); rx_valid = 1'b1; rx_data = b; t = cyc;
  endtask

  // build a well-formed frame holding the given words, optionally corrupting the checksum
  task automatic build(input logic [31:0] words[$], input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    frame.delete();
    frame.push_back(8'(words.size()));
    frame.push_back(8'(words.size() >> 8));
    foreach (words[i]) for (int k = 0; k < 4; k++) begin
      frame.push_back(words[i][8*k +: 8]);
      x ^= words[i][8*k +: 8];
    end
    frame.push_back(corrupt ? ~x : x);
  endtask

  // send 'frame', then compare against the frame-level model
  task automatic run_frame(input string name, input int maxgap);
    int t, n, nw;
    bit bad, exp_err;
    logic [7:0] x;
    int          e_adr[$];
    logic [31:0] e_dat[$];
    int          e_cyc[$];
    clear_obs();
    foreach (frame[i]) begin
      send(frame[i], (maxgap > 0) ? $urandom_range(maxgap, 0) : 0, t);
      tms.push_back(t);
    end
    @(negedge clk); rx_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    n   = int'({frame[1], frame[0]});
    bad = (n == 0) || (n > (1 << ADDR_W));
    if (bad) exp_err = 1'b1;
    else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        e_adr.push_back(i);
        e_dat.push_back({frame[4*i+5], frame[4*i+4], frame[4*i+3], frame[4*i+2]});
        e_cyc.push_back(tms[4*i+5] + 1);
        for (int k = 2; k < 6; k++) x ^= frame[4*i+k];
      end
      exp_err = (frame[4*n+2] != x);
    end

    chk({name, ".done"}, 64'(done), 64'(1));
    chk({name, ".err"},  64'(err),  64'(exp_err));
    chk({name, ".busy"}, 64'(busy), 64'(0));
    chk({name, ".nwr"},  64'(wr_adr.size()), 64'(e_adr.size()));
    nw = (wr_adr.size() < e_adr.size()) ? wr_adr.size() : e_adr.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s.adr%0d", name, i), 64'(wr_adr[i]), 64'(e_adr[i]));
      chk($sformatf("%s.dat%0d", name, i), 64'(wr_dat[i]), 64'(e_dat[i]));
      chk($sformatf("%s.lat%0d", name, i), 64'(wr_cyc[i]), 64'(e_cyc[i]));
    end
    do_reset();
  endtask

  initial begin
    logic [31:0] w[$];
    int t, seen;

    repeat (2) @(negedge clk);
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.err",  64'(err),  64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.wen",  64'(wen),  64'(0));
    chk("rst.adr",  64'(adr),  64'(0));
    chk("rst.dat",  64'(dat),  64'(0));
    rst = 1'b0;

    // idling in IDLE must never time out
    repeat (3 * TO) @(negedge clk);
    chk("idle.done", 64'(done), 64'(0));
    chk("idle.busy", 64'(busy), 64'(0));

    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame("single", 0);

    // XOR of the eight data bytes is 0x79
    frame = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'h79};
    run_frame("two_gap", 4);
    run_frame("two_b2b", 0);

    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF};
    run_frame("badcsum", 0);

    // trailing bytes after a bad count must be ignored
    frame = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame("cnt0", 1);
    frame = '{8'h01, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame("cnt16385", 1);

    // timeout after 0xBB
    clear_obs();
    send(8'h01, 0, t); send(8'h00, 0, t); send(8'hAA, 0, t); send(8'hBB, 0, t);
    @(negedge clk); rx_valid = 1'b0;
    chk("to.busy", 64'(busy), 64'(1));
    seen = -1;
    for (int i = 0; i < 4 * TO; i++) begin
      if (done === 1'b1 && seen < 0) seen = cyc;
      @(negedge clk);
    end
    chk("to.when", 64'(seen), 64'(t + 1 + TO));
    chk("to.err",  64'(err),  64'(1));
    chk("to.nwr",  64'(wr_adr.size()), 64'(0));
    do_reset();

    // reset in the middle of word 1: word 0 already written, partial word dropped
    clear_obs();
    foreach (frame[i]) ;
    frame = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0};
    foreach (frame[i]) send(frame[i], 0, t);
    @(negedge clk); rx_valid = 1'b0;
    chk("mid.pre_dat", 64'(dat), 64'(32'hDEADBEEF));
    rst = 1'b1;
    #1;
    chk("mid.wen",  64'(wen),  64'(0));
    chk("mid.adr",  64'(adr),  64'(0));
    chk("mid.dat",  64'(dat),  64'(0));
    chk("mid.done", 64'(done), 64'(0));
    chk("mid.err",  64'(err),  64'(0));
    chk("mid.busy", 64'(busy), 64'(0));
    chk("mid.nwr",  64'(wr_adr.size()), 64'(1));
    @(negedge clk); rst = 1'b0;
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame("after_rst", 0);

    // random frames
    for (int f = 0; f < 12; f++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) w.push_back($urandom);
      build(w, ($urandom_range(3, 0) == 0));
      run_frame($sformatf("rnd%0d", f), (f % 3 == 0) ? 0 : 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
